// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg : shared widths, arbiter state encoding and write-entry layout.
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ENTRY_W    = REG_ADDR_W + XLEN;

    typedef enum logic [0:0] {
        ARB_ALU_PRI   = 1'b0,
        ARB_LSU_FORCE = 1'b1
    } arb_state_t;

    // Buffered LSU result, laid out as {rd, data}
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo : DEPTH x WIDTH circular FIFO for buffered LSU write-back results.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : merges ALU and buffered LSU results onto the register
// file write port. Macro REGFILE_WB_BYPASS_EN adds fwd_* ports. Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [REG_ADDR_W-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [XLEN-1:0]       fwd_data,
`endif
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteAddr,
    output logic [XLEN-1:0]       WriteData
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_WAIT);

    arb_state_t       state;
    logic [AGE_W-1:0] age;
    logic [AGE_W-1:0] age_inc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             empty;
    logic             full;
    logic             alu_fire;
    logic             lsu_push;
    logic             fifo_pop;
    wb_entry_t        push_entry;
    wb_entry_t        head;

    always_comb begin
        alu_ready  = (state == ARB_ALU_PRI);
        alu_fire   = alu_valid && alu_ready;
        // Anything the ALU does not claim goes to the FIFO head, forced or not
        fifo_pop   = !empty && !alu_fire;
        lsu_push   = lsu_valid && lsu_ready && !full && (lsu_rd != '0);
        count_next = count + CNT_W'(lsu_push) - CNT_W'(fifo_pop);
        age_inc    = age + 1'b1;
        push_entry = '{rd: lsu_rd, data: lsu_data};
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (lsu_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_ALU_PRI;
            age       <= '0;
            lsu_ready <= 1'b0;
            RegWrite  <= 1'b0;
            WriteAddr <= '0;
            WriteData <= '0;
        end else begin
            lsu_ready <= (count_next < CNT_W'(DEPTH));
            RegWrite  <= 1'b0;
            if (alu_fire) begin
                if (alu_rd != '0) begin
                    RegWrite  <= 1'b1;
                    WriteAddr <= alu_rd;
                    WriteData <= alu_data;
                end
                if (!empty) begin
                    age <= age_inc;
                end
            end else if (fifo_pop) begin
                RegWrite  <= 1'b1;
                WriteAddr <= head.rd;
                WriteData <= head.data;
                age       <= '0;
            end

            case (state)
                ARB_ALU_PRI: begin
                    if (alu_fire && !empty && (age_inc == MAX_AGE)) begin
                        state <= ARB_LSU_FORCE;
                    end
                end
                ARB_LSU_FORCE: state <= ARB_ALU_PRI;
                default:       state <= ARB_ALU_PRI;
            endcase
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        fwd_hit  = RegWrite && (WriteAddr == fwd_addr) && (fwd_addr != '0);
        fwd_data = fwd_hit ? WriteData : '0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : queue-based reference model with scoreboard monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  fwd_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif
    logic [4:0]  fwd_sel = '0;

    regfile_wb_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
`ifdef REGFILE_WB_BYPASS_EN
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .RegWrite  (RegWrite),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: pending LSU results, wait age, forced flag, outputs
    ent_t        mq[$];
    int          m_age = 0;
    bit          m_forced = 1'b0;
    bit          m_lrdy = 1'b0;
    bit          m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("RegWrite", 32'(RegWrite), 32'(mon_e.we));
            check("WriteAddr", 32'(WriteAddr), 32'(mon_e.addr));
            check("WriteData", WriteData, mon_e.data);
        end
    end

    task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         output bit acc_alu, output bit acc_lsu);
        ent_t        head;
        bit          issue;
        logic [4:0]  ia;
        logic [31:0] idat;
`ifdef REGFILE_WB_BYPASS_EN
        bit          exp_hit;
`endif
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
`ifdef REGFILE_WB_BYPASS_EN
        fwd_addr  = fwd_sel;
`endif
        #1;
        check("alu_ready", 32'(alu_ready), 32'(!m_forced));
        check("lsu_ready", 32'(lsu_ready), 32'(m_lrdy));
`ifdef REGFILE_WB_BYPASS_EN
        exp_hit = m_we && (m_addr == fwd_sel) && (fwd_sel != 5'd0);
        check("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
        check("fwd_data", fwd_data, exp_hit ? m_data : 32'h0);
`endif
        acc_alu = av && !m_forced;
        acc_lsu = lv && m_lrdy;
        issue   = 1'b0;
        ia      = m_addr;
        idat    = m_data;
        if (acc_alu) begin
            if (ard != 5'd0) begin
                issue = 1'b1;
                ia    = ard;
                idat  = ad;
            end
            if (mq.size() > 0) m_age++;
        end else if (mq.size() > 0) begin
            head  = mq.pop_front();
            issue = 1'b1;
            ia    = head.rd;
            idat  = head.data;
            m_age = 0;
        end
        if (acc_lsu && lrd != 5'd0) mq.push_back('{rd: lrd, data: ld});
        m_forced = (mq.size() > 0) && (m_age == MAX_WAIT);
        m_lrdy   = (mq.size() < DEPTH);
        m_we     = issue;
        m_addr   = ia;
        m_data   = idat;
        exp_q.push_back('{we: issue, addr: ia, data: idat});
    endtask

    task automatic idle(input int n);
        bit a, l;
        repeat (n) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, a, l);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_RegWrite", 32'(RegWrite), 32'h0);
            check("rst_WriteAddr", 32'(WriteAddr), 32'h0);
            check("rst_WriteData", WriteData, 32'h0);
            check("rst_lsu_ready", 32'(lsu_ready), 32'h0);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("rel_lsu_ready", 32'(lsu_ready), 32'h0);
        exp_q.delete();
        mq.delete();
        m_age    = 0;
        m_forced = 1'b0;
        m_lrdy   = 1'b1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    initial begin
        bit aa, al;
        int waited;

        do_reset(3);

        // ALU only, then forwarding of the x5 write, then idle
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, aa, al);
        fwd_sel = 5'd5;
        idle(2);

        // x0 destinations are dropped on both paths
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678, aa, al);
        idle(2);

        // LSU only
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11, aa, al);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h22, aa, al);
        idle(3);

        // Starvation guard with the ALU held valid
        cycle(1'b1, 5'd1, 32'hA0, 1'b1, 5'd9, 32'h99, aa, al);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'(10 + i), 32'hB0 + 32'(i), 1'b0, 5'd0, 32'h0, aa, al);
        idle(2);

        // Fill the FIFO while the ALU keeps priority; fifth entry must wait
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd2, 32'hC0 + 32'(i), 1'b1, 5'(20 + i), 32'h100 + 32'(i), aa, al);
        waited = 0;
        al = 1'b0;
        while (!al && waited < 20) begin
            cycle(1'b1, 5'd3, 32'hD0 + 32'(waited), 1'b1, 5'd24, 32'h104, aa, al);
            waited++;
        end
        checks++;
        if (!al) begin
            errors++;
            $display("FIFO full: fifth LSU entry FAIL, not accepted within 20 cycles");
        end
        for (int i = 0; i < 20; i++) cycle(1'b1, 5'd4, 32'hE0 + 32'(i), 1'b0, 5'd0, 32'h0, aa, al);
        idle(8);

        // Reset with buffered entries: nothing stale may appear afterwards
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd6, 32'hF0 + 32'(i), 1'b1, 5'(25 + i), 32'h200 + 32'(i), aa, al);
        do_reset(2);
        idle(6);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            fwd_sel = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) < 5, 5'($urandom_range(0, 31)), $urandom, aa, al);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("Timeout FAIL: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
